system_top: RTL and testbench

Dual-port SPI register hub for the voice board top level. Two independent SPI slave ports, one for the Raspberry Pi host (rpi_*) and one for the ESP32 co-processor (esp_*), share a single internal bus. Behind that bus sit an ID/status page, a control register file, an inter-processor mailbox and a 256-word shared RAM. A live sample of the 8-bit PDM microphone data bus is readable on the status page.

---
 rtl/system_top.sv | 230 +++++++++++++++++++++++
 tb/tb_system_top.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_top.sv
// Dual-port SPI register hub: two SPI slave front-ends sharing one internal bus
// to a status page, control registers, an inter-processor mailbox and a shared RAM.

module spi_port (
  input  logic        clk_50,
  input  logic        resetn,
  input  logic        sck_i,
  input  logic        ss_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        req_o,
  output logic        we_o,
  output logic [14:0] addr_o,
  output logic [15:0] wdata_o,
  input  logic        ack_i,
  input  logic [15:0] rdata_i
);

  typedef enum logic [1:0] {PH_HDR, PH_WR, PH_RD} phase_e;

  logic [2:0]  sck_q;
  logic [1:0]  ss_q, mosi_q;
  logic        armed_q, req_q, we_q, first_q, miso_q;
  phase_e      phase_q;
  logic [3:0]  bit_cnt_q;
  logic [14:0] addr_q, req_addr_q;
  logic [15:0] shift_q, wdata_q, tx_q, nxt_q;

  logic        active, sck_rise, sck_fall;
  logic [15:0] shift_d, word_d;
  logic [3:0]  tx_idx;

  // After reset the port stays idle until ss has been seen high once.
  assign active   = armed_q & ~ss_q[1];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign shift_d  = {shift_q[14:0], mosi_q[1]};
  assign word_d   = {shift_d[7:0], shift_d[15:8]};
  // Wire order is low byte MSB first, then high byte MSB first.
  assign tx_idx   = {bit_cnt_q[3], ~bit_cnt_q[2:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50) begin
    if (!resetn) begin
      sck_q      <= '0;
      ss_q       <= '0;
      mosi_q     <= '0;
      armed_q    <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      first_q    <= 1'b0;
      miso_q     <= 1'b0;
      phase_q    <= PH_HDR;
      bit_cnt_q  <= '0;
      addr_q     <= '0;
      req_addr_q <= '0;
      shift_q    <= '0;
      wdata_q    <= '0;
      tx_q       <= '0;
      nxt_q      <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck_i};
      ss_q   <= {ss_q[0], ss_i};
      mosi_q <= {mosi_q[0], mosi_i};
      if (ss_q[1]) armed_q <= 1'b1;

      if (ack_i) begin
        req_q <= 1'b0;
        if (!we_q && phase_q == PH_RD) begin
          if (first_q) begin
            tx_q       <= rdata_i;
            miso_q     <= rdata_i[7];
            first_q    <= 1'b0;
            req_q      <= 1'b1;
            req_addr_q <= addr_q;
            addr_q     <= addr_q + 15'd1;
          end else begin
            nxt_q <= rdata_i;
          end
        end
      end

      if (!active) begin
        bit_cnt_q <= '0;
        phase_q   <= PH_HDR;
        miso_q    <= 1'b0;
        first_q   <= 1'b0;
      end else begin
        if (sck_fall && phase_q == PH_RD && !first_q) miso_q <= tx_q[tx_idx];
        if (sck_rise) begin
          shift_q   <= shift_d;
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            case (phase_q)
              PH_HDR: begin
                addr_q <= word_d[15:1];
                if (word_d[0]) begin
                  phase_q    <= PH_RD;
                  first_q    <= 1'b1;
                  req_q      <= 1'b1;
                  we_q       <= 1'b0;
                  req_addr_q <= word_d[15:1];
                  addr_q     <= word_d[15:1] + 15'd1;
                end else begin
                  phase_q <= PH_WR;
                end
              end
              PH_WR: begin
                req_q      <= 1'b1;
                we_q       <= 1'b1;
                wdata_q    <= word_d;
                req_addr_q <= addr_q;
                addr_q     <= addr_q + 15'd1;
              end
              default: begin
                tx_q       <= nxt_q;
                req_q      <= 1'b1;
                we_q       <= 1'b0;
                req_addr_q <= addr_q;
                addr_q     <= addr_q + 15'd1;
              end
            endcase
          end
        end
      end
    end
  end

  assign miso_o  = miso_q;
  assign req_o   = req_q;
  assign we_o    = we_q;
  assign addr_o  = req_addr_q;
  assign wdata_o = wdata_q;

endmodule

module system_top #(
  parameter int          RAM_DEPTH = 256,
  parameter logic [15:0] ID_VALUE  = 16'h5643,
  parameter logic [15:0] VERSION   = 16'h0001
) (
  input  logic       clk_50,
  input  logic       resetn,
  input  logic       rpi_sck,
  input  logic       rpi_ss,
  input  logic       rpi_mosi,
  output logic       rpi_miso,
  input  logic       esp_sck,
  input  logic       esp_ss,
  input  logic       esp_mosi,
  output logic       esp_miso,
  input  logic [7:0] pdm_data
);

  logic        rpi_req, rpi_we, esp_req, esp_we;
  logic [14:0] rpi_addr, esp_addr, bus_addr;
  logic [15:0] rpi_wdata, esp_wdata, bus_wdata, bus_rdata;
  logic        gnt_rpi, gnt_esp, bus_req, bus_we, bus_wr;
  logic        sel_stat, sel_ram, sel_ctrl, sel_mbox;

  logic [7:0]  pdm_q;
  logic [15:0] ctrl_q [16];
  logic [15:0] mbox_q [4];
  logic [15:0] ram_q  [RAM_DEPTH];

  spi_port u_rpi (
    .clk_50, .resetn,
    .sck_i(rpi_sck), .ss_i(rpi_ss), .mosi_i(rpi_mosi), .miso_o(rpi_miso),
    .req_o(rpi_req), .we_o(rpi_we), .addr_o(rpi_addr), .wdata_o(rpi_wdata),
    .ack_i(gnt_rpi), .rdata_i(bus_rdata)
  );

  spi_port u_esp (
    .clk_50, .resetn,
    .sck_i(esp_sck), .ss_i(esp_ss), .mosi_i(esp_mosi), .miso_o(esp_miso),
    .req_o(esp_req), .we_o(esp_we), .addr_o(esp_addr), .wdata_o(esp_wdata),
    .ack_i(gnt_esp), .rdata_i(bus_rdata)
  );

  // RPi has fixed priority; a losing ESP request stays raised and is served next cycle.
  assign gnt_rpi   = rpi_req;
  assign gnt_esp   = esp_req & ~rpi_req;
  assign bus_req   = rpi_req | esp_req;
  assign bus_we    = rpi_req ? rpi_we    : esp_we;
  assign bus_addr  = rpi_req ? rpi_addr  : esp_addr;
  assign bus_wdata = rpi_req ? rpi_wdata : esp_wdata;
  assign bus_wr    = bus_req & bus_we;

  assign sel_stat = (bus_addr[14:8] == 7'h00) && (bus_addr[7:4] == 4'h0);
  assign sel_ram  = (bus_addr[14:8] == 7'h20);
  assign sel_ctrl = (bus_addr[14:8] == 7'h40) && (bus_addr[7:4] == 4'h0);
  assign sel_mbox = (bus_addr[14:8] == 7'h50) && (bus_addr[7:2] == 6'h00);

  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    bus_rdata = '0;
    if (sel_stat) begin
      case (bus_addr[3:0])
        4'h0:    bus_rdata = ID_VALUE;
        4'h1:    bus_rdata = VERSION;
        4'h7:    bus_rdata = {8'h00, pdm_q};
        default: bus_rdata = '0;
      endcase
    end else if (sel_ram) begin
      bus_rdata = ram_q[bus_addr[7:0]];
    end else if (sel_ctrl) begin
      bus_rdata = ctrl_q[bus_addr[3:0]];
    end else if (sel_mbox) begin
      bus_rdata = mbox_q[bus_addr[1:0]];
    end
  end

  always_ff @(posedge clk_50) begin
    if (!resetn) begin
      pdm_q <= '0;
      for (int i = 0; i < 16; i++) ctrl_q[i] <= '0;
      for (int i = 0; i < 4; i++)  mbox_q[i] <= '0;
    end else begin
      pdm_q <= pdm_data;
      if (bus_wr && sel_ctrl) ctrl_q[bus_addr[3:0]] <= bus_wdata;
      if (bus_wr && sel_mbox) mbox_q[bus_addr[1:0]] <= bus_wdata;
    end
  end

  // NOTE: the RAM has no reset so it maps onto plain memory and keeps its contents.
  always_ff @(posedge clk_50) begin
    if (resetn && bus_wr && sel_ram) ram_q[bus_addr[7:0]] <= bus_wdata;
  end

endmodule

// File: tb/tb_system_top.sv
// Self-checking bench for system_top: SPI master tasks on both ports, checked
// against an address-range reference model of the register hub.

module tb_system_top;

  localparam int HALF = 6;

  logic       clk_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       rpi_sck = 1'b1, rpi_ss = 1'b1, rpi_mosi = 1'b0;
  logic       esp_sck = 1'b1, esp_ss = 1'b1, esp_mosi = 1'b0;
  logic       rpi_miso, esp_miso;
  logic [7:0] pdm_data = 8'h00;

  int total = 0;
  int bad   = 0;

  logic [15:0] wbuf [2][32];
  logic [15:0] rbuf [2][32];

  logic [15:0] m_ram  [256];
  logic [15:0] m_ctrl [16];
  logic [15:0] m_mbox [4];

  system_top dut (
    .clk_50(clk_50), .resetn(resetn),
    .rpi_sck(rpi_sck), .rpi_ss(rpi_ss), .rpi_mosi(rpi_mosi), .rpi_miso(rpi_miso),
    .esp_sck(esp_sck), .esp_ss(esp_ss), .esp_mosi(esp_mosi), .esp_miso(esp_miso),
    .pdm_data(pdm_data)
  );

  always #10 clk_50 = ~clk_50;

  // Reference model, written in terms of address ranges.
  function automatic logic [15:0] model_read(input logic [14:0] a);
    if (a == 15'h0000) return 16'h5643;
    if (a == 15'h0001) return 16'h0001;
    if (a == 15'h0007) return {8'h00, pdm_data};
    if (a >= 15'h2000 && a <= 15'h20FF) return m_ram[int'(a) - 'h2000];
    if (a >= 15'h4000 && a <= 15'h400F) return m_ctrl[int'(a) - 'h4000];
    if (a >= 15'h5000 && a <= 15'h5003) return m_mbox[int'(a) - 'h5000];
    return 16'h0000;
  endfunction

  task automatic model_write(input logic [14:0] a, input logic [15:0] d);
    if (a >= 15'h2000 && a <= 15'h20FF) m_ram[int'(a) - 'h2000] = d;
    else if (a >= 15'h4000 && a <= 15'h400F) m_ctrl[int'(a) - 'h4000] = d;
    else if (a >= 15'h5000 && a <= 15'h5003) m_mbox[int'(a) - 'h5000] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctrl[i] = 16'h0000;
    for (int i = 0; i < 4; i++)  m_mbox[i] = 16'h0000;
  endtask

  // SPI master helpers
  task automatic drive(input int p, input logic sck, input logic mosi);
    if (p == 0) begin rpi_sck = sck; rpi_mosi = mosi; end
    else        begin esp_sck = sck; esp_mosi = mosi; end
  endtask

  task automatic set_ss(input int p, input logic v);
    if (p == 0) rpi_ss = v; else esp_ss = v;
  endtask

  function automatic logic get_miso(input int p);
    return (p == 0) ? rpi_miso : esp_miso;
  endfunction

  task automatic spi_bits(input int p, input logic [15:0] tx, input int nbits,
                          output logic [15:0] rx);
    logic [7:0] ob [2];
    logic [7:0] ib [2];
    ob[0] = tx[7:0];
    ob[1] = tx[15:8];
    ib[0] = 8'h00;
    ib[1] = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int b, j;
      b = i / 8;
      j = 7 - (i % 8);
      drive(p, 1'b0, ob[b][j]);
      repeat (HALF) @(negedge clk_50);
      ib[b][j] = get_miso(p);
      drive(p, 1'b1, ob[b][j]);
      repeat (HALF) @(negedge clk_50);
    end
    rx = {ib[1], ib[0]};
  endtask

  task automatic spi_open(input int p);
    set_ss(p, 1'b0);
    repeat (6) @(negedge clk_50);
  endtask

  task automatic spi_close(input int p);
    set_ss(p, 1'b1);
    repeat (10) @(negedge clk_50);
  endtask

  task automatic do_write(input int p, input logic [14:0] addr, input int n);
    logic [15:0] rx;
    spi_open(p);
    spi_bits(p, {addr, 1'b0}, 16, rx);
    for (int k = 0; k < n; k++) spi_bits(p, wbuf[p][k], 16, rx);
    spi_close(p);
  endtask

  task automatic do_read(input int p, input logic [14:0] addr, input int n);
    logic [15:0] rx;
    spi_open(p);
    spi_bits(p, {addr, 1'b1}, 16, rx);
    for (int k = 0; k < n; k++) begin
      spi_bits(p, $urandom, 16, rx);
      rbuf[p][k] = rx;
    end
    spi_close(p);
  endtask

  // Tests
  task automatic test_reset();
    logic [14:0] addrs [5];
    addrs[0] = 15'h0000; addrs[1] = 15'h0001; addrs[2] = 15'h0003;
    addrs[3] = 15'h4000; addrs[4] = 15'h5003;
    resetn = 1'b0;
    repeat (4) @(negedge clk_50);
    total++;
    if (rpi_miso !== 1'b0) begin bad++; $display("FAIL reset_rpi_miso: got %b expected 0", rpi_miso); end
    total++;
    if (esp_miso !== 1'b0) begin bad++; $display("FAIL reset_esp_miso: got %b expected 0", esp_miso); end
    resetn = 1'b1;
    model_reset();
    repeat (6) @(negedge clk_50);
    for (int i = 0; i < 5; i++) begin
      do_read(i % 2, addrs[i], 1);
      total++;
      if (rbuf[i % 2][0] !== model_read(addrs[i])) begin
        bad++;
        $display("FAIL reset_read @%h: got %h expected %h", addrs[i], rbuf[i % 2][0], model_read(addrs[i]));
      end
    end
  endtask

  task automatic test_ctrl();
    wbuf[0][0] = 16'h0001; do_write(0, 15'h400C, 1); model_write(15'h400C, 16'h0001);
    wbuf[0][0] = 16'h0000; do_write(0, 15'h400C, 1); model_write(15'h400C, 16'h0000);
    do_read(0, 15'h400C, 1);
    total++;
    if (rbuf[0][0] !== model_read(15'h400C)) begin
      bad++; $display("FAIL ctrl_400C: got %h expected %h", rbuf[0][0], model_read(15'h400C));
    end
    do_read(0, 15'h400B, 1);
    total++;
    if (rbuf[0][0] !== model_read(15'h400B)) begin
      bad++; $display("FAIL ctrl_400B: got %h expected %h", rbuf[0][0], model_read(15'h400B));
    end
  endtask

  task automatic test_burst();
    for (int k = 0; k < 17; k++) begin
      wbuf[0][k] = 16'h0100 + 16'(k);
      model_write(15'h2000 + 15'(k), wbuf[0][k]);
    end
    do_write(0, 15'h2000, 17);
    do_read(0, 15'h2000, 17);
    for (int k = 0; k < 17; k++) begin
      total++;
      if (rbuf[0][k] !== model_read(15'h2000 + 15'(k))) begin
        bad++;
        $display("FAIL burst word %0d: got %h expected %h", k, rbuf[0][k], model_read(15'h2000 + 15'(k)));
      end
    end
  endtask

  task automatic test_pdm();
    logic [7:0] pats [2];
    pats[0] = 8'hAA; pats[1] = 8'h55;
    for (int i = 0; i < 2; i++) begin
      pdm_data = pats[i];
      do_read(0, 15'h0007, 1);
      total++;
      if (rbuf[0][0] !== model_read(15'h0007)) begin
        bad++; $display("FAIL pdm_%h: got %h expected %h", pats[i], rbuf[0][0], model_read(15'h0007));
      end
    end
  endtask

  task automatic test_mailbox();
    for (int k = 0; k < 4; k++) begin
      wbuf[1][k] = 16'hABCF;
      model_write(15'h5000 + 15'(k), 16'hABCF);
    end
    do_write(1, 15'h5000, 4);
    do_read(0, 15'h5000, 4);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rbuf[0][k] !== model_read(15'h5000 + 15'(k))) begin
        bad++; $display("FAIL mailbox %0d: got %h expected %h", k, rbuf[0][k], model_read(15'h5000 + 15'(k)));
      end
    end
  endtask

  task automatic test_readonly();
    wbuf[1][0] = 16'hCDFA;
    do_write(1, 15'h0000, 1);
    model_write(15'h0000, 16'hCDFA);
    do_read(1, 15'h0000, 1);
    total++;
    if (rbuf[1][0] !== model_read(15'h0000)) begin
      bad++; $display("FAIL readonly_id: got %h expected %h", rbuf[1][0], model_read(15'h0000));
    end
  endtask

  task automatic test_back_to_back();
    wbuf[0][0] = 16'h1357;
    wbuf[1][0] = 16'h2468;
    fork
      do_write(0, 15'h2055, 1);
      do_write(1, 15'h2055, 1);
    join
    model_write(15'h2055, 16'h1357);
    model_write(15'h2055, 16'h2468);
    do_read(0, 15'h2055, 1);
    total++;
    if (rbuf[0][0] !== model_read(15'h2055)) begin
      bad++; $display("FAIL same_cycle_write: got %h expected %h", rbuf[0][0], model_read(15'h2055));
    end
  endtask

  task automatic test_abort();
    logic [15:0] rx;
    spi_open(0);
    spi_bits(0, {15'h4005, 1'b0}, 16, rx);
    spi_bits(0, 16'hBEEF, 8, rx);
    spi_close(0);
    do_read(1, 15'h4005, 1);
    total++;
    if (rbuf[1][0] !== model_read(15'h4005)) begin
      bad++; $display("FAIL ss_abort: got %h expected %h", rbuf[1][0], model_read(15'h4005));
    end
  endtask

  task automatic test_reset_midword();
    logic [15:0] rx;
    wbuf[0][0] = 16'h1111;
    do_write(0, 15'h2010, 1);
    model_write(15'h2010, 16'h1111);
    spi_open(0);
    spi_bits(0, {15'h2010, 1'b0}, 16, rx);
    spi_bits(0, 16'h2222, 10, rx);
    resetn = 1'b0;
    repeat (3) @(negedge clk_50);
    total++;
    if (rpi_miso !== 1'b0) begin bad++; $display("FAIL midreset_miso: got %b expected 0", rpi_miso); end
    resetn = 1'b1;
    model_reset();
    spi_bits(0, 16'h2222, 6, rx);
    spi_close(0);
    do_read(1, 15'h2010, 1);
    total++;
    if (rbuf[1][0] !== model_read(15'h2010)) begin
      bad++; $display("FAIL midreset_ram: got %h expected %h", rbuf[1][0], model_read(15'h2010));
    end
    wbuf[0][0] = 16'h3333;
    do_write(0, 15'h2010, 1);
    model_write(15'h2010, 16'h3333);
    do_read(0, 15'h2010, 1);
    total++;
    if (rbuf[0][0] !== model_read(15'h2010)) begin
      bad++; $display("FAIL postreset_write: got %h expected %h", rbuf[0][0], model_read(15'h2010));
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [14:0] base;
      int len, wp, rp;
      case ($urandom_range(0, 4))
        0:       base = 15'h2000 + 15'($urandom_range(0, 255));
        1:       base = 15'h4000 + 15'($urandom_range(0, 17));
        2:       base = 15'h5000 + 15'($urandom_range(0, 5));
        3:       base = 15'($urandom_range(0, 15));
        default: base = 15'($urandom_range(0, 32767));
      endcase
      len = $urandom_range(1, 5);
      wp  = $urandom_range(0, 1);
      rp  = $urandom_range(0, 1);
      for (int k = 0; k < len; k++) begin
        wbuf[wp][k] = 16'($urandom);
        model_write(base + 15'(k), wbuf[wp][k]);
      end
      do_write(wp, base, len);
      pdm_data = 8'($urandom);
      do_read(rp, base, len);
      for (int k = 0; k < len; k++) begin
        total++;
        if (rbuf[rp][k] !== model_read(base + 15'(k))) begin
          bad++;
          $display("FAIL random @%h: got %h expected %h", base + 15'(k), rbuf[rp][k], model_read(base + 15'(k)));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_burst();
    test_pdm();
    test_mailbox();
    test_readonly();
    test_back_to_back();
    test_abort();
    test_reset_midword();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
